// File: rtl/branch_redirect_unit.sv
// Fetch PC sequencer: redirects on taken branches/jumps from EX and sequences the IF/ID/EX flush.
// Optional macro BRANCH_PERF_EN enables the br_count / br_taken_count performance counters.
module branch_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        brq,
    input  logic [31:0] ex_target,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic        flush,
    output logic        misalign_exc,
    output logic [31:0] br_count,
    output logic [31:0] br_taken_count
);

    typedef enum logic [1:0] {RUN, FLUSH, PEND} state_t;

    localparam logic [2:0] FC = FLUSH_CYCLES[2:0];

    state_t      state, state_nx;
    logic [31:0] pc_nx, pend_tgt, pend_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        flush_nx, mis_nx;
    logic        take, bad, redirect;

    assign take     = ex_valid & (ex_is_jump | (ex_is_branch & brq));
    assign bad      = take & (ex_target[1:0] != 2'b00);
    assign redirect = take & ~bad;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        cnt_nx   = cnt;
        pend_nx  = pend_tgt;
        mis_nx   = 1'b0;
        case (state)
            RUN: begin
                mis_nx = bad;
                if (redirect) begin
                    if (stall) begin
                        pend_nx  = ex_target;
                        state_nx = PEND;
                    end else begin
                        pc_nx    = ex_target;
                        cnt_nx   = FC;
                        state_nx = FLUSH;
                    end
                end else if (!stall) begin
                    pc_nx = pc + 32'd4;
                end
            end
            FLUSH: begin
                // Counter runs regardless of stall; EX only holds bubbles here.
                cnt_nx = cnt - 3'd1;
                if (!stall)
                    pc_nx = pc + 32'd4;
                if (cnt <= 3'd1)
                    state_nx = RUN;
            end
            PEND: begin
                if (!stall) begin
                    pc_nx    = pend_tgt;
                    cnt_nx   = FC;
                    state_nx = FLUSH;
                end
            end
            default: state_nx = RUN;
        endcase
        flush_nx = (state_nx == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            pc           <= RESET_PC;
            cnt          <= 3'd0;
            pend_tgt     <= 32'h0;
            flush        <= 1'b0;
            if_valid     <= 1'b1;
            misalign_exc <= 1'b0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            cnt          <= cnt_nx;
            pend_tgt     <= pend_nx;
            flush        <= flush_nx;
            if_valid     <= ~flush_nx;
            misalign_exc <= mis_nx;
        end
    end

`ifdef BRANCH_PERF_EN
    logic [31:0] br_cnt_q, br_tk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= 32'h0;
            br_tk_q  <= 32'h0;
        end else if (state == RUN && ex_valid && ex_is_branch) begin
            br_cnt_q <= br_cnt_q + 32'd1;
            if (brq)
                br_tk_q <= br_tk_q + 32'd1;
        end
    end

    assign br_count       = br_cnt_q;
    assign br_taken_count = br_tk_q;
`else
    assign br_count       = 32'h0;
    assign br_taken_count = 32'h0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Bench for branch_redirect_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch_redirect_unit;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          FC       = 2;

    logic        clk = 1'b0;
    logic        rst, stall, ex_valid, ex_is_branch, ex_is_jump, brq;
    logic [31:0] ex_target;
    logic [31:0] pc, br_count, br_taken_count;
    logic        if_valid, flush, misalign_exc;

    branch_redirect_unit #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .brq(brq),
        .ex_target(ex_target), .pc(pc), .if_valid(if_valid), .flush(flush),
        .misalign_exc(misalign_exc), .br_count(br_count), .br_taken_count(br_taken_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: remaining flush cycles, a pending-redirect flag, and the plain counters.
    logic [31:0] m_pc, m_tgt, m_brc, m_brt;
    int          m_flush_left;
    bit          m_pend, m_mis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit v, input bit b, input bit j,
                         input bit q, input logic [31:0] t);
        rst = r; stall = s; ex_valid = v; ex_is_branch = b; ex_is_jump = j; brq = q; ex_target = t;
    endtask

    task automatic model_edge();
        bit tk, bd;
        if (rst) begin
            m_pc = RESET_PC; m_flush_left = 0; m_pend = 0; m_tgt = 0; m_mis = 0;
            m_brc = 0; m_brt = 0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            m_mis = 0;
            if (!stall) m_pc += 4;
        end else if (m_pend) begin
            m_mis = 0;
            if (!stall) begin m_pc = m_tgt; m_flush_left = FC; m_pend = 0; end
        end else begin
            tk = ex_valid && (ex_is_jump || (ex_is_branch && brq));
            bd = tk && (ex_target % 4 != 0);
            m_mis = bd;
            if (ex_valid && ex_is_branch) begin
                m_brc++;
                if (brq) m_brt++;
            end
            if (tk && !bd) begin
                if (stall) begin m_pend = 1; m_tgt = ex_target; end
                else begin m_pc = ex_target; m_flush_left = FC; end
            end else if (!stall) begin
                m_pc += 4;
            end
        end
    endtask

    task automatic compare_all();
        chk("pc", pc, m_pc);
        chk("flush", {31'b0, flush}, {31'b0, m_flush_left > 0});
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_flush_left == 0});
        chk("misalign_exc", {31'b0, misalign_exc}, {31'b0, m_mis});
`ifdef BRANCH_PERF_EN
        chk("br_count", br_count, m_brc);
        chk("br_taken_count", br_taken_count, m_brt);
`else
        chk("br_count", br_count, 32'h0);
        chk("br_taken_count", br_taken_count, 32'h0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 32'h0);
            step();
        end
    endtask

    logic [31:0] held_pc;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        m_pc = 32'hx; m_flush_left = 0; m_pend = 0; m_mis = 0; m_tgt = 0; m_brc = 0; m_brt = 0;

        // Reset and sequential fetch
        step(); step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_ifv", {31'b0, if_valid}, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            chk("seq_pc", pc, 32'(i * 4));
            chk("seq_flush", {31'b0, flush}, 32'h0);
        end

        // Taken beq to 0x100
        drive(0, 0, 1, 1, 0, 1, 32'h100); step();
        chk("beq_pc_n1", pc, 32'h100);
        chk("beq_flush_n1", {31'b0, flush}, 32'h1);
        idle(1);
        chk("beq_flush_n2", {31'b0, flush}, 32'h1);
        chk("beq_ifv_n2", {31'b0, if_valid}, 32'h0);
        idle(1);
        chk("beq_ifv_n3", {31'b0, if_valid}, 32'h1);
        chk("beq_pc_n3", pc, 32'h108);

        // Not-taken branch at 0x20 from a fresh reset
        drive(1, 0, 0, 0, 0, 0, 32'h0); step();
        idle(8);
        chk("nt_pc_at", pc, 32'h20);
        drive(0, 0, 1, 1, 0, 0, 32'h400); step();
        chk("nt_pc", pc, 32'h24);
        chk("nt_flush", {31'b0, flush}, 32'h0);

        // jal to 0x200 held in EX under a 3-cycle stall
        held_pc = pc;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 1, 0, 32'h200); step();
            chk("stall_hold", pc, held_pc);
        end
        drive(0, 0, 1, 0, 1, 0, 32'h200); step();
        chk("stall_redir_pc", pc, 32'h200);
        chk("stall_flush1", {31'b0, flush}, 32'h1);
        idle(1);
        chk("stall_flush2", {31'b0, flush}, 32'h1);
        idle(1);
        chk("stall_flush_end", {31'b0, flush}, 32'h0);

        // Misaligned taken target
        held_pc = pc;
        drive(0, 0, 1, 1, 0, 1, 32'h102); step();
        chk("mis_pulse", {31'b0, misalign_exc}, 32'h1);
        chk("mis_pc", pc, held_pc + 32'd4);
        idle(1);
        chk("mis_clear", {31'b0, misalign_exc}, 32'h0);

        // PC wrap past 0xFFFF_FFFC
        drive(0, 0, 1, 0, 1, 0, 32'hFFFF_FFF8); step();
        idle(1);
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        idle(1);
        chk("wrap_pc", pc, 32'h0);

        // Reset one cycle after a redirect
        drive(0, 0, 1, 0, 1, 0, 32'h300); step();
        drive(1, 0, 0, 0, 0, 0, 32'h0); step();
        chk("rstmid_pc", pc, RESET_PC);
        chk("rstmid_flush", {31'b0, flush}, 32'h0);
        chk("rstmid_ifv", {31'b0, if_valid}, 32'h1);
        chk("rstmid_brc", br_count, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] t;
            t = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(7) == 0) t[1:0] = 2'($urandom_range(1, 3));
            drive($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(3) != 0,
                  $urandom_range(1) == 1, $urandom_range(5) == 0, $urandom_range(1) == 1, t);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
